cb_seg_size_pipe: RTL and testbench

Parametrised successor to the byte-domain code-block size calculator. Accepts transport-block sizes (bytes, CRC already attached) over a valid/ready stream and classifies each into a count of large (C_plus) and small (C_minus) code blocks plus a filler count. Results go through a 2-stage pipeline into an internal first-word-fall-through result FIFO. Sits between the TB-CRC attach stage and the segmentation/filler-insertion engine.

---
 rtl/cb_seg_size_pipe_pkg.sv | 46 ++++
 rtl/cb_seg_size_pipe_classify.sv | 39 +++
 rtl/cb_seg_size_pipe.sv | 132 +++++++++++++
 tb/tb_cb_seg_size_pipe.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cb_seg_size_pipe_pkg.sv
// Shared types, C-count encodings and threshold derivation for the code-block size pipeline.
package cb_seg_pkg;

    localparam int unsigned CB_FILLER_MAX_W = 16;

    localparam logic [1:0] CB_C_NONE = 2'd0;
    localparam logic [1:0] CB_C_ONE  = 2'd1;
    localparam logic [1:0] CB_C_TWO  = 2'd2;

    // Filler is carried at a fixed maximum width; the top resizes it to FILL_W.
    typedef struct packed {
        logic                       err;
        logic [1:0]                 c_plus;
        logic [1:0]                 c_minus;
        logic [CB_FILLER_MAX_W-1:0] filler;
    } cb_result_t;

    typedef struct packed {
        logic [31:0] t_low;
        logic [31:0] t_mid;
        logic [31:0] t_high;
        logic [31:0] t_max;
    } cb_thr_t;

    function automatic cb_thr_t cb_thresholds(input int unsigned k_plus,
                                              input int unsigned k_minus,
                                              input int unsigned crc_bytes);
        cb_thr_t t;
        t.t_low  = k_minus;
        t.t_mid  = k_plus;
        t.t_high = k_plus + k_minus - 2 * crc_bytes;
        t.t_max  = 2 * k_plus - 2 * crc_bytes;
        return t;
    endfunction

    // Largest filler any band can produce (band floor is previous threshold + 1).
    function automatic int unsigned cb_max_filler(input cb_thr_t t);
        int unsigned m;
        m = t.t_low;
        if (t.t_mid - t.t_low - 1 > m)   m = t.t_mid - t.t_low - 1;
        if (t.t_high - t.t_mid - 1 > m)  m = t.t_high - t.t_mid - 1;
        if (t.t_max - t.t_high - 1 > m)  m = t.t_max - t.t_high - 1;
        return m;
    endfunction

endpackage

// File: rtl/cb_seg_size_pipe_classify.sv
// Combinational classifier: transport-block size in bytes -> code-block counts and filler.
module cb_seg_classify
    import cb_seg_pkg::*;
#(
    parameter int unsigned SIZE_W    = 12,
    parameter int unsigned K_PLUS    = 768,
    parameter int unsigned K_MINUS   = 132,
    parameter int unsigned CRC_BYTES = 3
) (
    input  logic [SIZE_W-1:0] size,
    output cb_result_t        result
);

    localparam cb_thr_t THR = cb_thresholds(K_PLUS, K_MINUS, CRC_BYTES);

    logic [31:0] b;

    always_comb begin
        b      = 32'(size);
        result = '0;
        if (b > THR.t_max) begin
            result.err = 1'b1;
        end else if (b > THR.t_high) begin
            result.c_plus = CB_C_TWO;
            result.filler = CB_FILLER_MAX_W'(THR.t_max - b);
        end else if (b > THR.t_mid) begin
            result.c_plus  = CB_C_ONE;
            result.c_minus = CB_C_ONE;
            result.filler  = CB_FILLER_MAX_W'(THR.t_high - b);
        end else if (b > THR.t_low) begin
            result.c_plus = CB_C_ONE;
            result.filler = CB_FILLER_MAX_W'(THR.t_mid - b);
        end else begin
            result.c_minus = CB_C_ONE;
            result.filler  = CB_FILLER_MAX_W'(THR.t_low - b);
        end
    end

endmodule

// File: rtl/cb_seg_size_pipe.sv
// Code-block size pipeline: size register, classify stage and inline FWFT result FIFO.
// Optional CB_SEG_SIZE_STATS_EN adds saturating written-result and error counters.
module cb_seg_size_pipe
    import cb_seg_pkg::*;
#(
    parameter int unsigned SIZE_W    = 12,
    parameter int unsigned FILL_W    = 10,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned K_PLUS    = 768,
    parameter int unsigned K_MINUS   = 132,
    parameter int unsigned CRC_BYTES = 3
) (
    input  logic                       clk,
    input  logic                       aclr_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SIZE_W-1:0]          in_size,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_c_plus,
    output logic [1:0]                 out_c_minus,
    output logic [FILL_W-1:0]          out_filler,
    output logic                       out_err,
    output logic [$clog2(DEPTH+1)-1:0] level
`ifdef CB_SEG_SIZE_STATS_EN
    ,
    output logic [31:0]                stat_blocks,
    output logic [15:0]                stat_errs
`endif
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned LW        = $clog2(DEPTH + 1);
    localparam cb_thr_t     THR       = cb_thresholds(K_PLUS, K_MINUS, CRC_BYTES);
    localparam int unsigned FILL_NEED = $clog2(cb_max_filler(THR) + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("cb_seg_size_pipe: DEPTH must be a power of two and at least 2");
    end
    if (FILL_W < FILL_NEED || FILL_NEED > CB_FILLER_MAX_W) begin : g_bad_fill
        $error("cb_seg_size_pipe: FILL_W too narrow for the largest filler");
    end

    logic              s1_valid;
    logic [SIZE_W-1:0] s1_size;
    logic              ready_en;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    cb_result_t        mem [DEPTH];
    cb_result_t        s2_result;
    cb_result_t        head;
    logic              accept;
    logic              wr_en;
    logic              rd_en;
    logic [LW:0]       credit;

    cb_seg_classify #(
        .SIZE_W    (SIZE_W),
        .K_PLUS    (K_PLUS),
        .K_MINUS   (K_MINUS),
        .CRC_BYTES (CRC_BYTES)
    ) u_classify (
        .size   (s1_size),
        .result (s2_result)
    );

    // Credit counts both queued results and the word in stage 1, so the FIFO can never overflow.
    assign credit    = {1'b0, level} + (LW + 1)'(s1_valid);
    assign in_ready  = ready_en && (credit < (LW + 1)'(DEPTH));
    assign out_valid = (level != '0);
    assign accept    = in_valid && in_ready;
    assign wr_en     = s1_valid && !flush;
    assign rd_en     = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            ready_en <= 1'b0;
            s1_valid <= 1'b0;
            s1_size  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
        end else begin
            ready_en <= 1'b1;
            if (flush) begin
                s1_valid <= 1'b0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                level    <= '0;
            end else begin
                s1_valid <= accept;
                if (accept) s1_size <= in_size;
                if (wr_en)  wr_ptr  <= wr_ptr + AW'(1);
                if (rd_en)  rd_ptr  <= rd_ptr + AW'(1);
                case ({wr_en, rd_en})
                    2'b10:   level <= level + LW'(1);
                    2'b01:   level <= level - LW'(1);
                    default: level <= level;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= s2_result;
    end

    always_comb begin
        head        = out_valid ? mem[rd_ptr] : '0;
        out_err     = head.err;
        out_c_plus  = head.c_plus;
        out_c_minus = head.c_minus;
        out_filler  = FILL_W'(head.filler);
    end

`ifdef CB_SEG_SIZE_STATS_EN
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            stat_blocks <= '0;
            stat_errs   <= '0;
        end else if (flush) begin
            stat_blocks <= '0;
            stat_errs   <= '0;
        end else if (wr_en) begin
            if (stat_blocks != '1) stat_blocks <= stat_blocks + 32'd1;
            if (s2_result.err && stat_errs != '1) stat_errs <= stat_errs + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cb_seg_size_pipe.sv
// Directed self-checking bench for cb_seg_size_pipe (default parameters).
module tb_cb_seg_size_pipe;

    logic        clk;
    logic        aclr_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_size;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_c_plus;
    logic [1:0]  out_c_minus;
    logic [9:0]  out_filler;
    logic        out_err;
    logic [2:0]  level;
`ifdef CB_SEG_SIZE_STATS_EN
    logic [31:0] stat_blocks;
    logic [15:0] stat_errs;
`endif

    int checks = 0;
    int errors = 0;

    cb_seg_size_pipe #(
        .SIZE_W    (12),
        .FILL_W    (10),
        .DEPTH     (4),
        .K_PLUS    (768),
        .K_MINUS   (132),
        .CRC_BYTES (3)
    ) dut (
        .clk         (clk),
        .aclr_n      (aclr_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_size     (in_size),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_c_plus  (out_c_plus),
        .out_c_minus (out_c_minus),
        .out_filler  (out_filler),
        .out_err     (out_err),
        .level       (level)
`ifdef CB_SEG_SIZE_STATS_EN
        ,
        .stat_blocks (stat_blocks),
        .stat_errs   (stat_errs)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated word with out_ready=1: accepted at edge N, head valid after N+1.
    task automatic send_one(input int unsigned b, input int unsigned cp, input int unsigned cm,
                            input int unsigned fl, input int unsigned er);
        in_valid = 1'b1;
        in_size  = 12'(b);
        check($sformatf("ready_b%0d", b), in_ready, 1);
        step();
        in_valid = 1'b0;
        check($sformatf("lat_b%0d", b), out_valid, 0);
        step();
        check($sformatf("valid_b%0d", b), out_valid, 1);
        check($sformatf("cplus_b%0d", b), out_c_plus, cp);
        check($sformatf("cminus_b%0d", b), out_c_minus, cm);
        check($sformatf("filler_b%0d", b), out_filler, fl);
        check($sformatf("err_b%0d", b), out_err, er);
    endtask

    initial begin
        int unsigned sent;
        int unsigned popped;
        logic        acc;

        aclr_n    = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_size   = '0;
        out_ready = 1'b1;

        #3;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_filler", out_filler, 0);
        check("rst_cminus", out_c_minus, 0);
        #19;
        aclr_n = 1'b1;
        #1;
        check("rel_in_ready_before_edge", in_ready, 0);
        step();
        check("rel_in_ready_after_edge", in_ready, 1);

        // Band boundaries
        send_one(0,    0, 1, 132, 0);
        send_one(132,  0, 1, 0,   0);
        send_one(133,  1, 0, 635, 0);
        send_one(768,  1, 0, 0,   0);
        send_one(769,  1, 1, 125, 0);
        send_one(894,  1, 1, 0,   0);
        send_one(895,  2, 0, 635, 0);
        send_one(1530, 2, 0, 0,   0);
        send_one(1531, 0, 0, 0,   1);
        send_one(4095, 0, 0, 0,   1);
        send_one(700,  1, 0, 68,  0);
        step();
        check("idle_level", level, 0);

        // Backpressure: only DEPTH words fit
        out_ready = 1'b0;
        sent = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            in_valid = 1'b1;
            in_size  = 12'(100 + sent);
            acc = in_ready;
            step();
            if (acc) sent++;
        end
        check("bp_accepted", sent, 4);
        check("bp_in_ready", in_ready, 0);
        check("bp_level", level, 4);

        out_ready = 1'b1;
        popped = 0;
        for (int cyc = 0; cyc < 30 && popped < 6; cyc++) begin
            in_valid = (sent < 6);
            in_size  = 12'(100 + sent);
            acc = in_valid && in_ready;
            if (out_valid) begin
                check($sformatf("bp_order_%0d", popped), out_filler, 32 - popped);
                check($sformatf("bp_cminus_%0d", popped), out_c_minus, 1);
                popped++;
            end
            step();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        check("bp_popped", popped, 6);
        check("bp_sent", sent, 6);
        check("bp_drained", level, 0);

        // Simultaneous write and pop at level 2
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_size  = 12'(10 + i);
            step();
        end
        in_valid = 1'b0;
        check("sim_level_pre", level, 2);
        out_ready = 1'b1;
        step();
        check("sim_level_both", level, 2);
        check("sim_head_11", out_filler, 121);
        step();
        check("sim_level_1", level, 1);
        check("sim_head_12", out_filler, 120);
        step();
        check("sim_empty", out_valid, 0);

        // Flush with level 3, stage 1 occupied and a word offered
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_size  = 12'(20 + i);
            step();
        end
        check("fl_level_pre", level, 3);
        check("fl_ready_pre", in_ready, 0);
        in_valid = 1'b1;
        in_size  = 12'd24;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_level", level, 0);
        check("fl_out_valid", out_valid, 0);
        check("fl_in_ready", in_ready, 1);
        check("fl_filler", out_filler, 0);
        step();
        check("fl_no_late_write", level, 0);
        check("fl_out_valid2", out_valid, 0);

        // Asynchronous reset between edges
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_size  = 12'(30 + i);
            step();
        end
        in_valid = 1'b0;
        step();
        check("ar_level_pre", level, 2);
        #2;
        aclr_n = 1'b0;
        #1;
        check("ar_level", level, 0);
        check("ar_out_valid", out_valid, 0);
        check("ar_in_ready", in_ready, 0);
        check("ar_filler", out_filler, 0);
        check("ar_cminus", out_c_minus, 0);
        #2;
        aclr_n = 1'b1;
        step();
        check("ar_ready_back", in_ready, 1);
        check("ar_level_post", level, 0);

`ifdef CB_SEG_SIZE_STATS_EN
        begin
            int unsigned sz [10];
            sz = '{50, 2000, 300, 1500, 800, 4095, 10, 1000, 1531, 0};
            check("st_blocks_rst", stat_blocks, 0);
            check("st_errs_rst", stat_errs, 0);
            out_ready = 1'b1;
            for (int i = 0; i < 10; i++) begin
                in_valid = 1'b1;
                in_size  = 12'(sz[i]);
                check($sformatf("st_ready_%0d", i), in_ready, 1);
                step();
            end
            in_valid = 1'b0;
            step();
            step();
            check("st_blocks", stat_blocks, 10);
            check("st_errs", stat_errs, 3);
            flush = 1'b1;
            step();
            flush = 1'b0;
            check("st_blocks_flush", stat_blocks, 0);
            check("st_errs_flush", stat_errs, 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
